// File: rtl/sauria_demo_ctrl_regs.sv
// sauria_demo_ctrl_regs: reg-bus control/status window for the SAURIA accelerator
module sauria_demo_ctrl_regs #(
    parameter int AddrWidth  = 48,
    parameter int DataWidth  = 32,
    parameter int OffsetBits = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_req_valid_i,
    input  logic [AddrWidth-1:0]   reg_req_addr_i,
    input  logic                   reg_req_write_i,
    input  logic [DataWidth-1:0]   reg_req_wdata_i,
    input  logic [DataWidth/8-1:0] reg_req_wstrb_i,
    output logic                   reg_rsp_ready_o,
    output logic [DataWidth-1:0]   reg_rsp_rdata_o,
    output logic                   reg_rsp_error_o,
    output logic                   start_o,
    input  logic                   done_i,
    output logic [DataWidth-1:0]   cfg_addr_o,
    output logic                   irq_o
);
    typedef enum logic {IDLE, ACK} state_t;
    state_t state;
    logic busy, done, irq_en;
    logic [DataWidth-1:0] cycles, cfg_addr, scratch, cfg_nx, scr_nx, rd_val;
    logic [OffsetBits-1:0] off;
    logic accept, wr, hit_ctrl, hit_stat, hit_cyc, hit_cfg, hit_scr, miss;
    logic wr_ctrl, wr_stat, start_go, done_go, w1c;
    logic unused_addr;
    assign unused_addr = ^reg_req_addr_i[AddrWidth-1:OffsetBits];
    assign off      = reg_req_addr_i[OffsetBits-1:0];
    assign accept   = (state == IDLE) && reg_req_valid_i;
    assign wr       = accept && reg_req_write_i;
    assign hit_ctrl = off == OffsetBits'('h00);
    assign hit_stat = off == OffsetBits'('h04);
    assign hit_cyc  = off == OffsetBits'('h08);
    assign hit_cfg  = off == OffsetBits'('h0C);
    assign hit_scr  = off == OffsetBits'('h10);
    // Misaligned addresses never match a word offset, so they fall into miss too
    assign miss     = !(hit_ctrl || hit_stat || hit_cyc || hit_cfg || hit_scr);
    assign wr_ctrl  = wr && hit_ctrl && reg_req_wstrb_i[0];
    assign wr_stat  = wr && hit_stat && reg_req_wstrb_i[0];
    assign start_go = wr_ctrl && reg_req_wdata_i[0] && !busy;
    assign done_go  = done_i && busy;
    assign w1c      = wr_stat && reg_req_wdata_i[1];
    assign cfg_addr_o = cfg_addr;
    always_comb begin
        cfg_nx = cfg_addr;
        scr_nx = scratch;
        for (int i = 0; i < DataWidth/8; i++)
            if (reg_req_wstrb_i[i]) begin
                cfg_nx[8*i +: 8] = reg_req_wdata_i[8*i +: 8];
                scr_nx[8*i +: 8] = reg_req_wdata_i[8*i +: 8];
            end
        rd_val = hit_ctrl ? DataWidth'({irq_en, 1'b0}) :
                 hit_stat ? DataWidth'({done, busy}) :
                 hit_cyc  ? cycles :
                 hit_cfg  ? cfg_addr :
                 hit_scr  ? scratch : '0;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            reg_rsp_ready_o <= 1'b0;
            reg_rsp_rdata_o <= '0;
            reg_rsp_error_o <= 1'b0;
            start_o         <= 1'b0;
            irq_o           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            irq_en          <= 1'b0;
            cycles          <= '0;
            cfg_addr        <= '0;
            scratch         <= '0;
        end else begin
            state           <= accept ? ACK : IDLE;
            reg_rsp_ready_o <= accept;
            reg_rsp_rdata_o <= (accept && !reg_req_write_i) ? rd_val : '0;
            reg_rsp_error_o <= accept && miss;
            start_o         <= start_go;
            irq_o           <= done && irq_en;
            if (done_go) busy <= 1'b0;
            else if (start_go) busy <= 1'b1;
            // A completion arriving on the same edge as a W1C keeps DONE set
            if (done_go) done <= 1'b1;
            else if (start_go || w1c) done <= 1'b0;
            if (start_go) cycles <= '0;
            else if (busy && cycles != '1) cycles <= cycles + 1'b1;
            if (wr_ctrl) irq_en <= reg_req_wdata_i[1];
            if (wr && hit_cfg) cfg_addr <= cfg_nx;
            if (wr && hit_scr) scratch <= scr_nx;
        end
    end
endmodule

// File: doc/sauria_demo_ctrl_regs.md
# sauria_demo_ctrl_regs

Register-bus responder hanging off Cheshire's single external Reg slave port; it is the control/status window through which the CVA6 host drives the SAURIA accelerator. It decodes 32-bit register accesses, issues a single-cycle start pulse to SAURIA, and tracks busy/done. It also counts run cycles and raises a level interrupt on completion.

## Interface
- AddrWidth, 48, width of reg-bus address (Cheshire reg bus)
- DataWidth, 32, reg-bus data width; only 32 supported
- OffsetBits, 12, low address bits decoded; upper bits ignored (crossbar already selected this window)
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-high reset
- reg_req_valid_i  in  1  request valid, held until reg_rsp_ready_o
- reg_req_addr_i  in  AddrWidth  byte address
- reg_req_write_i  in  1  1 = write, 0 = read
- reg_req_wdata_i  in  32  write data
- reg_req_wstrb_i  in  4  byte strobes
- reg_rsp_ready_o  out  1  response valid/request accepted
- reg_rsp_rdata_o  out  32  read data
- reg_rsp_error_o  out  1  access error
- start_o  out  1  one-cycle start pulse to SAURIA
- done_i  in  1  one-cycle completion pulse from SAURIA
- cfg_addr_o  out  32  SAURIA descriptor base address (CFG_ADDR register)
- irq_o  out  1  level interrupt to host

## Operation
- Register map (offset = addr[OffsetBits-1:0], word aligned):
  - 0x00 CTRL: bit0 START (write-1, reads 0), bit1 IRQ_EN (RW); others read 0
  - 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (write-1-to-clear); others read 0
  - 0x08 CYCLES: RO, cycles of current/last run
  - 0x0C CFG_ADDR: RW, drives cfg_addr_o
  - 0x10 SCRATCH: RW, no side effects
- Byte strobes: CFG_ADDR/SCRATCH updated per byte lane; CTRL/STATUS act only if wstrb[0]=1.
- Any other offset, or addr[1:0]≠0: error=1, rdata=0, no state change. Writes to CYCLES: ignored, error=0.
- Responder FSM: IDLE → (valid) ACK → IDLE. Access decoded and write side effects committed on the edge leaving IDLE; ACK drives ready=1 with registered rdata/error. In IDLE, ready=0, rdata=0, error=0.
- START write accepted only when BUSY=0 at the accepting edge: sets BUSY, clears DONE, clears CYCLES, asserts start_o for the ACK cycle. START while BUSY=1: ignored, error=0.
- done_i while BUSY=1: clears BUSY, sets DONE. done_i while BUSY=0: ignored.
- Same-edge done_i and START write while busy: done processed, START ignored.
- Same-edge done_i set and DONE W1C: set wins.
- CYCLES increments by 1 each cycle BUSY=1, saturating at 0xFFFF_FFFF; frozen when idle.
- irq_o = registered (DONE & IRQ_EN); cleared by DONE W1C or IRQ_EN=0.

## Timing
- Reset (async, rst_i=1): FSM IDLE; ready/rdata/error/start_o/irq_o = 0; BUSY, DONE, IRQ_EN = 0; CYCLES, CFG_ADDR, SCRATCH = 0; cfg_addr_o = 0.
- Read/write latency: request seen at cycle N (IDLE) → ready at N+1. Throughput: one access per 2 cycles; requester drops or changes valid after ready.
- start_o high exactly 1 cycle (N+1), coincident with ready.
- STATUS.BUSY reads 1 on any read accepted after the START edge.
- DONE set at edge after done_i; irq_o one cycle later.
- Reset mid-run: all state cleared immediately; start_o never glitches high.

## Test plan
- Reset, read all 5 registers → rdata 0, error 0, ready exactly one cycle after each valid.
- Write 0x8000_1000 to CFG_ADDR with wstrb 0x3, then 0xF → cfg_addr_o 0x0000_1000 then 0x8000_1000; SCRATCH readback equal.
- Write CTRL=0x3, hold done_i low 10 cycles, pulse done_i → start_o one pulse, STATUS 0x1 during run, then 0x2; CYCLES = 11 (counts from start edge to done edge inclusive); irq_o=1; write STATUS=0x2 → irq_o=0.
- Write START while busy → no start_o pulse, CYCLES keeps counting, error 0; done_i with START same edge → BUSY 0, DONE 1, no start_o.
- Access offset 0x14 and 0x02 → error 1, rdata 0, no register changes.
- Assert rst_i during run at CYCLES=5 → all outputs 0 immediately, STATUS reads 0 after release.
